// File: rtl/sa_job_sequencer_if.sv
// Signal bundle linking the job sequencer to the host descriptor port, the
// systolic-array accelerator and the byte-wide result memory.
interface sa_job_sequencer_if;
  logic        job_valid;
  logic        job_ready;
  logic [9:0]  job_addr_a;
  logic [9:0]  job_addr_b;
  logic [9:0]  job_addr_c;
  logic        acc_clr;
  logic        acc_start;
  logic [9:0]  acc_addr_a;
  logic [9:0]  acc_addr_b;
  logic        acc_done;
  logic [5:0]  res_sel;
  logic [15:0] res_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wd;

  modport master (
    input  job_valid, job_addr_a, job_addr_b, job_addr_c,
    output job_ready,
    output acc_clr, acc_start, acc_addr_a, acc_addr_b,
    input  acc_done,
    output res_sel,
    input  res_data,
    output mem_req, mem_addr, mem_wd,
    input  mem_gnt
  );

  modport slave (
    output job_valid, job_addr_a, job_addr_b, job_addr_c,
    input  job_ready,
    input  acc_clr, acc_start, acc_addr_a, acc_addr_b,
    output acc_done,
    input  res_sel,
    output res_data,
    input  mem_req, mem_addr, mem_wd,
    output mem_gnt
  );
endinterface

// File: rtl/sa_job_sequencer.sv
// Job-level controller for the 8x8 systolic array: queues descriptors, clears and
// launches the array, watches for done with a watchdog, drains 64x16-bit results bytewise.
module sa_job_sequencer #(
  parameter int DEPTH      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  sa_job_sequencer_if.master  bus,
  output logic                busy,
  output logic                job_done,
  output logic [7:0]          jobs_cnt,
  output logic                err_timeout
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [7:0]       WD_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, FINISH} state_t;
  state_t state, state_nxt;

  logic [9:0]       q_a [DEPTH];
  logic [9:0]       q_b [DEPTH];
  logic [9:0]       q_c [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   q_cnt;
  logic             full, empty, push, pop;

  logic [9:0]       job_a, job_b, job_c;
  logic [CLR_W-1:0] clr_cnt;
  logic [7:0]       wd_cnt;
  logic [5:0]       k;
  logic             p;
  logic             clr_last, wd_expire, drain_last;

  assign full       = (q_cnt == DEPTH_CNT);
  assign empty      = (q_cnt == '0);
  assign push       = bus.job_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign clr_last   = (clr_cnt == CLR_LAST);
  assign wd_expire  = (wd_cnt == WD_LAST);
  assign drain_last = bus.mem_gnt && p && (k == 6'd63);

  // Descriptor storage needs no reset: occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_a[wr_ptr] <= bus.job_addr_a;
      q_b[wr_ptr] <= bus.job_addr_b;
      q_c[wr_ptr] <= bus.job_addr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + (PTR_W + 1)'(1);
        2'b01:   q_cnt <= q_cnt - (PTR_W + 1)'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A done seen in the same cycle the watchdog expires still counts as success.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = RUN;
      RUN: begin
        if (bus.acc_done)   state_nxt = DRAIN;
        else if (wd_expire) state_nxt = IDLE;
      end
      DRAIN:   if (drain_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      job_a       <= '0;
      job_b       <= '0;
      job_c       <= '0;
      clr_cnt     <= '0;
      wd_cnt      <= '0;
      k           <= '0;
      p           <= 1'b0;
      jobs_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pop) begin
        job_a <= q_a[rd_ptr];
        job_b <= q_b[rd_ptr];
        job_c <= q_c[rd_ptr];
      end
      clr_cnt <= (state == CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      wd_cnt  <= (state == RUN) ? wd_cnt + 8'd1 : 8'd0;
      if (state == RUN && !bus.acc_done && wd_expire) err_timeout <= 1'b1;
      // k wraps back to 0 on the final grant, leaving res_sel at 0 between jobs.
      if (state == DRAIN && bus.mem_gnt) begin
        p <= ~p;
        if (p) k <= k + 6'd1;
      end
      if (state == FINISH) jobs_cnt <= jobs_cnt + 8'd1;
    end
  end

  assign bus.job_ready  = !full;
  assign bus.acc_clr    = (state == CLEAR);
  assign bus.acc_start  = (state == RUN);
  assign bus.acc_addr_a = job_a;
  assign bus.acc_addr_b = job_b;
  assign bus.res_sel    = k;
  assign bus.mem_req    = (state == DRAIN);
  assign bus.mem_addr   = bus.mem_req ? job_c + {3'b000, k, p} : 10'd0;
  assign bus.mem_wd     = bus.mem_req ? (p ? bus.res_data[15:8] : bus.res_data[7:0]) : 8'd0;
  assign busy           = (state != IDLE);
  assign job_done       = (state == FINISH);
endmodule

// File: tb/tb_sa_job_sequencer.sv
// Scoreboard bench for sa_job_sequencer: a behavioural accelerator and memory model
// checks launch addresses, run lengths, every drained byte and the job counters.
module tb_sa_job_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy, job_done, err_timeout;
  logic [7:0] jobs_cnt;

  sa_job_sequencer_if bus_if ();

  sa_job_sequencer #(.DEPTH(4), .CLR_CYCLES(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .busy(busy), .job_done(job_done), .jobs_cnt(jobs_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  assign bus_if.res_data = 16'hA000 | {10'd0, bus_if.res_sel};

  typedef struct { logic [9:0] a, b, c; int da; } job_t;
  typedef struct { logic [9:0] addr; logic [7:0] wd; logic [5:0] sel; } wr_t;

  job_t exp_jobs[$];
  wr_t  exp_wr[$];
  job_t cur_job;
  int   total = 0, bad = 0;
  int   exp_done = 0, done_seen = 0;
  int   run_cnt = 0, cur_da = 0, drain_cyc = 0, gnt_mode = 0;
  logic prev_start = 1'b0;
  logic [9:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string t);
    check({t, "_rdy"},    32'(bus_if.job_ready),  32'd1);
    check({t, "_clr"},    32'(bus_if.acc_clr),    32'd0);
    check({t, "_start"},  32'(bus_if.acc_start),  32'd0);
    check({t, "_aa"},     32'(bus_if.acc_addr_a), 32'd0);
    check({t, "_ab"},     32'(bus_if.acc_addr_b), 32'd0);
    check({t, "_sel"},    32'(bus_if.res_sel),    32'd0);
    check({t, "_req"},    32'(bus_if.mem_req),    32'd0);
    check({t, "_maddr"},  32'(bus_if.mem_addr),   32'd0);
    check({t, "_mwd"},    32'(bus_if.mem_wd),     32'd0);
    check({t, "_busy"},   32'(busy),              32'd0);
    check({t, "_jdone"},  32'(job_done),          32'd0);
    check({t, "_jcnt"},   32'(jobs_cnt),          32'd0);
    check({t, "_err"},    32'(err_timeout),       32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic push_job(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input int da);
    int   n = 0;
    job_t j;
    wr_t  w;
    while (!bus_if.job_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.job_ready) begin
      check("push_wait", 32'd0, 32'd1);
      return;
    end
    bus_if.job_valid  = 1'b1;
    bus_if.job_addr_a = a;
    bus_if.job_addr_b = b;
    bus_if.job_addr_c = c;
    @(posedge clk);
    j.a = a; j.b = b; j.c = c; j.da = da;
    exp_jobs.push_back(j);
    if (da != 0) begin
      exp_done++;
      for (int kk = 0; kk < 64; kk++) begin
        for (int pp = 0; pp < 2; pp++) begin
          w.addr = 10'(int'(c) + 2 * kk + pp);
          w.wd   = (pp == 1) ? 8'hA0 : 8'(kk);
          w.sel  = 6'(kk);
          exp_wr.push_back(w);
        end
      end
    end
    @(negedge clk);
    bus_if.job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || exp_jobs.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy || exp_jobs.size() != 0), 32'd0);
  endtask

  // Accelerator, result memory and scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      prev_start      = 1'b0;
      run_cnt         = 0;
      drain_cyc       = 0;
      bus_if.acc_done = 1'b0;
      bus_if.mem_gnt  = 1'b1;
    end else begin
      if (bus_if.acc_start) begin
        if (!prev_start) begin
          run_cnt = 0;
          if (exp_jobs.size() == 0) begin
            check("start_unexp", 32'd1, 32'd0);
            cur_da = 1;
          end else begin
            cur_job = exp_jobs.pop_front();
            check("acc_addr_a", 32'(bus_if.acc_addr_a), 32'(cur_job.a));
            check("acc_addr_b", 32'(bus_if.acc_addr_b), 32'(cur_job.b));
            cur_da = cur_job.da;
          end
        end
        run_cnt++;
        bus_if.acc_done = (cur_da != 0) && (run_cnt == cur_da);
      end else begin
        bus_if.acc_done = 1'b0;
        if (prev_start) check("run_len", 32'(run_cnt), (cur_da == 0) ? 32'd255 : 32'(cur_da));
      end
      prev_start = bus_if.acc_start;

      if (gnt_mode == 0) bus_if.mem_gnt = 1'b1;
      else               bus_if.mem_gnt = bus_if.mem_req ? ~bus_if.mem_gnt : 1'b1;

      if (bus_if.mem_req) begin
        drain_cyc++;
        if (exp_wr.size() == 0) begin
          check("wr_unexp", 32'd1, 32'd0);
        end else begin
          check("mem_addr", 32'(bus_if.mem_addr), 32'(exp_wr[0].addr));
          check("mem_wd",   32'(bus_if.mem_wd),   32'(exp_wr[0].wd));
          check("res_sel",  32'(bus_if.res_sel),  32'(exp_wr[0].sel));
          if (bus_if.mem_gnt) begin
            last_addr = bus_if.mem_addr;
            void'(exp_wr.pop_front());
          end
        end
      end
      if (job_done) begin
        check("drain_len", 32'(drain_cyc), (gnt_mode != 0) ? 32'd256 : 32'd128);
        drain_cyc = 0;
        done_seen++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=time_limit expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus_if.job_valid  = 1'b0;
    bus_if.job_addr_a = '0;
    bus_if.job_addr_b = '0;
    bus_if.job_addr_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst("rst0");
    rst = 1'b1;

    // Single job with launch timing
    push_job(10'h000, 10'h040, 10'h100, 30);
    check("t_clr0", 32'(bus_if.acc_clr), 32'd0);
    @(negedge clk);
    check("t_clr1", 32'(bus_if.acc_clr), 32'd1);
    check("t_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("t_clr2", 32'(bus_if.acc_clr), 32'd1);
    check("t_start2", 32'(bus_if.acc_start), 32'd0);
    @(negedge clk);
    check("t_start3", 32'(bus_if.acc_start), 32'd1);
    check("t_clr3", 32'(bus_if.acc_clr), 32'd0);
    wait_idle(2000);
    check("j1_cnt", 32'(jobs_cnt), 32'd1);
    check("j1_done", 32'(done_seen), 32'd1);
    check("j1_last", 32'(last_addr), 32'h17F);

    // Five jobs offered while busy: queue fills after four
    push_job(10'h010, 10'h020, 10'h200, 5);
    n = 0;
    while (!bus_if.acc_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    push_job(10'h011, 10'h021, 10'h210, 6);
    push_job(10'h012, 10'h022, 10'h220, 7);
    push_job(10'h013, 10'h023, 10'h230, 8);
    push_job(10'h014, 10'h024, 10'h240, 9);
    check("q_full", 32'(bus_if.job_ready), 32'd0);
    push_job(10'h015, 10'h025, 10'h250, 10);
    wait_idle(5000);
    check("b2b_cnt", 32'(jobs_cnt), 32'(exp_done));
    check("b2b_done", 32'(done_seen), 32'(exp_done));

    // Toggling grant doubles the drain
    gnt_mode = 1;
    push_job(10'h100, 10'h140, 10'h000, 10);
    wait_idle(2000);
    gnt_mode = 0;
    check("tg_cnt", 32'(jobs_cnt), 32'(exp_done));

    // Result address wraps past 0x3FF
    push_job(10'h0AA, 10'h0BB, 10'h3F0, 7);
    wait_idle(2000);
    check("wrap_last", 32'(last_addr), 32'h06F);
    check("wrap_cnt", 32'(jobs_cnt), 32'(exp_done));

    // Reset mid-drain with a second job still queued
    push_job(10'h055, 10'h066, 10'h080, 4);
    push_job(10'h077, 10'h088, 10'h180, 4);
    n = 0;
    while (!(bus_if.mem_req && bus_if.res_sel == 6'd20) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("k20_reached", 32'(bus_if.res_sel), 32'd20);
    rst = 1'b0;
    @(posedge clk);
    exp_wr.delete();
    exp_jobs.delete();
    exp_done  = 0;
    done_seen = 0;
    @(negedge clk);
    check_rst("rst1");
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rq_busy", 32'(busy), 32'd0);
    check("rq_req", 32'(bus_if.mem_req), 32'd0);

    // Done coincident with the watchdog limit
    push_job(10'h111, 10'h122, 10'h300, 255);
    wait_idle(3000);
    check("co_err", 32'(err_timeout), 32'd0);
    check("co_cnt", 32'(jobs_cnt), 32'd1);

    // Watchdog abort, then a normal job
    push_job(10'h1A0, 10'h1B0, 10'h040, 0);
    check("to_err0", 32'(err_timeout), 32'd0);
    push_job(10'h1C0, 10'h1D0, 10'h0C0, 9);
    wait_idle(3000);
    check("to_err1", 32'(err_timeout), 32'd1);
    check("to_cnt", 32'(jobs_cnt), 32'(exp_done));
    check("to_done", 32'(done_seen), 32'(exp_done));

    check("sb_wr_left", 32'(exp_wr.size()), 32'd0);
    check("sb_job_left", 32'(exp_jobs.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sa_job_sequencer.md
# sa_job_sequencer

Job-level controller for the 8x8 systolic-array accelerator. Queues matrix-multiply job descriptors from the host, then for each job clears the array, holds the accelerator's start level until it signals done, and drains the 64 16-bit results to byte-wide memory. A watchdog aborts jobs whose done never arrives. It sits between the host/testbench and the accelerator top.

## Interface

- DEPTH, 4: job descriptor queue depth (power of 2, ≥2)
- CLR_CYCLES, 2: cycles acc_clr is held before launch (≥1)
- TIMEOUT, 255: max RUN cycles waiting for acc_done (1..255)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- job_valid  in  1  descriptor offered
- job_ready  out  1  queue not full
- job_addr_a / job_addr_b / job_addr_c  in  10 each  A base, B base, C result base byte address
- acc_clr  out  1  clears array accumulators/FIFOs (active-high)
- acc_start  out  1  level start to accelerator, held high for whole computation
- acc_addr_a / acc_addr_b  out  10 each  bases of current job, stable while acc_start high
- acc_done  in  1  accelerator done
- res_sel  out  6  index of result element Crc being read, {r[2:0],c[2:0]}
- res_data  in  16  selected element, combinational from res_sel
- mem_req  out  1  write request; mem_addr/mem_wd valid when high
- mem_gnt  in  1  write accepted this cycle when mem_req & mem_gnt
- mem_addr  out  10  byte write address
- mem_wd  out  8  byte write data
- busy  out  1  state ≠ IDLE
- job_done  out  1  one-cycle pulse per completed job
- jobs_cnt  out  8  completed-job counter, wraps 255→0
- err_timeout  out  1  sticky; set on watchdog abort, cleared only by reset

## Operation

- Queue: push on job_valid & job_ready; job_ready = !full. Pop only on IDLE→CLEAR. Push and pop same cycle legal when not full; occupancy unchanged.
- FSM states IDLE, CLEAR, RUN, DRAIN, FINISH. Outputs are Moore decodes of registered state/counters.
- IDLE: if queue non-empty, pop head into job registers, → CLEAR.
- CLEAR: acc_clr=1 for CLR_CYCLES cycles, → RUN.
- RUN: acc_start=1, acc_addr_a/b = job registers. Watchdog counts RUN cycles from 1. acc_done=1 → DRAIN (done wins over a same-cycle timeout). Count reaches TIMEOUT with acc_done low → set err_timeout, → IDLE (no drain, no job_done, jobs_cnt unchanged).
- DRAIN: element index k (0..63) and byte phase p. res_sel=k; mem_req=1; mem_addr = (addr_c + 2k + p) mod 1024; mem_wd = p ? res_data[15:8] : res_data[7:0] (little-endian). Advance p (then k) only on mem_gnt; without grant all outputs hold. Grant on k=63,p=1 → FINISH.
- FINISH: job_done=1 one cycle, jobs_cnt+1, → IDLE.
- acc_start low in every state but RUN; acc_clr low in every state but CLEAR; mem_req low outside DRAIN.
- Reset (any state, incl. mid-RUN/DRAIN): state IDLE, queue emptied, counters 0, job registers 0.
- Reset values: job_ready=1, acc_clr=0, acc_start=0, acc_addr_a/b=0, res_sel=0, mem_req=0, mem_addr=0, mem_wd=0, busy=0, job_done=0, jobs_cnt=0, err_timeout=0.

## Timing

- Descriptor pushed at edge T into empty queue, FSM IDLE: CLEAR from T+1, acc_clr high T+1..T+CLR_CYCLES, acc_start high from T+CLR_CYCLES+1.
- acc_done sampled high at edge D: acc_start low and DRAIN from D; first mem_req in cycle after D.
- With mem_gnt tied high, DRAIN is exactly 128 cycles; job_done pulses in the cycle after the last grant; IDLE next cycle, so back-to-back queued jobs relaunch (CLEAR) 2 cycles after job_done.
- Job overhead beyond accelerator compute: CLR_CYCLES + 128 + 2 cycles minimum.
- Timeout abort: err_timeout and IDLE take effect at the edge ending the TIMEOUT-th RUN cycle.

## Test plan

- Single job A=0x000, B=0x040, C=0x100, acc_done after 30 RUN cycles, gnt=1, res_data=0xA000|res_sel → 128 writes, addr 0x100..0x17F, byte at 0x101+2k = 0xA0, at 0x100+2k = k; one job_done; jobs_cnt=1.
- Push 5 jobs back-to-back with FSM busy, DEPTH=4 → job_ready low after 4th push held until first pop; all jobs complete in push order with correct acc_addr_a/b.
- mem_gnt toggling 1-0 → mem_addr/mem_wd/res_sel held on every ungranted cycle; still exactly 128 writes, DRAIN 256 cycles.
- acc_done never asserted, TIMEOUT=255 → acc_start falls after 255 RUN cycles, err_timeout=1 sticky, no writes, no job_done; next queued job then runs normally.
- C=0x3F0 → addresses wrap 0x3FF→0x000; last write at 0x06F.
- rst low during DRAIN at k=20 → next cycle all outputs at reset values, queue empty, no further writes; acc_done=1 with acc_done and timeout coincident → drain proceeds, err_timeout stays 0.
